// File: rtl/response_meter.sv
// response_meter: measures the player's response time after a Simon sequence.
// Counts prescaled ticks from a start event until the first stop (button
// press), or reports a timeout once the latched limit of ticks has elapsed.
module response_meter #(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] limit,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] elapsed
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state;
    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] elapsed_next;

    // Candidate tick count; never wraps because elapsed stays below lim while running.
    always_comb begin
        elapsed_next = elapsed + CNT_W'(1);
    end

    // Measurement state machine: start restarts from any state, stop wins over the tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pre     <= '0;
            lim     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            elapsed <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (start) begin
                pre     <= '0;
                elapsed <= '0;
                lim     <= limit;
                if (limit == '0) begin
                    state   <= HOLD;
                    busy    <= 1'b0;
                    timeout <= 1'b1;
                end else begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end else if (state == RUN) begin
                if (stop) begin
                    state <= HOLD;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else if (pre == PRE_MAX) begin
                    pre     <= '0;
                    elapsed <= elapsed_next;
                    if (elapsed_next == lim) begin
                        state   <= HOLD;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end else begin
                    pre <= pre + PRE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_response_meter.sv
// Testbench for response_meter: table-driven measurement scenarios, hand-written
// restart / async-reset sequences and randomized traffic against a reference model.
module tb_response_meter;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] limit;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] elapsed;

    int checks = 0;
    int errors = 0;

    // Reference model: measurement described as edge count since start.
    bit m_run, m_busy, m_done, m_timeout;
    int m_n, m_lim, m_elapsed;

    typedef struct {
        int lim;
        int stop_at;
        int exp_elapsed;
        bit exp_done;
        bit exp_timeout;
        int exp_end;
    } vec_t;

    vec_t vecs[8];

    response_meter #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .stop    (stop),
        .limit   (limit),
        .busy    (busy),
        .done    (done),
        .timeout (timeout),
        .elapsed (elapsed)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== 32'(expected)) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_busy = 0; m_done = 0; m_timeout = 0;
        m_n = 0; m_lim = 0; m_elapsed = 0;
    endtask

    // After n edges since start, floor(n/TICK_DIV) ticks have elapsed; a stop
    // freezes the count from before its own edge; timeout occurs at n == lim*TICK_DIV.
    task automatic model_step(input bit s, input bit p, input int l);
        m_done = 0;
        m_timeout = 0;
        if (s) begin
            m_lim = l;
            m_n = 0;
            m_elapsed = 0;
            if (l == 0) begin
                m_run = 0; m_busy = 0; m_timeout = 1;
            end else begin
                m_run = 1; m_busy = 1;
            end
        end else if (m_run) begin
            m_n++;
            if (p) begin
                m_elapsed = (m_n - 1) / TICK_DIV;
                m_run = 0; m_busy = 0; m_done = 1;
            end else begin
                m_elapsed = m_n / TICK_DIV;
                if (m_n == m_lim * TICK_DIV) begin
                    m_run = 0; m_busy = 0; m_timeout = 1;
                end
            end
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, ".busy"}, 32'(busy), int'(m_busy));
        check({tag, ".done"}, 32'(done), int'(m_done));
        check({tag, ".timeout"}, 32'(timeout), int'(m_timeout));
        check({tag, ".elapsed"}, 32'(elapsed), m_elapsed);
    endtask

    // Drive one cycle of inputs, advance the model on the edge, sample 1 unit later.
    task automatic apply_stimulus(input bit s, input bit p, input int l, input string tag);
        start = s;
        stop  = p;
        limit = CNT_W'(l);
        @(posedge clk);
        model_step(s, p, l);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        check_output(tag);
    endtask

    initial begin
        int pulse_at;
        int pulse_elapsed;
        bit got_done;
        bit got_timeout;

        vecs[0] = '{lim: 10,  stop_at: 14, exp_elapsed: 3,   exp_done: 1, exp_timeout: 0, exp_end: 14};
        vecs[1] = '{lim: 5,   stop_at: 0,  exp_elapsed: 5,   exp_done: 0, exp_timeout: 1, exp_end: 20};
        vecs[2] = '{lim: 3,   stop_at: 12, exp_elapsed: 2,   exp_done: 1, exp_timeout: 0, exp_end: 12};
        vecs[3] = '{lim: 0,   stop_at: 0,  exp_elapsed: 0,   exp_done: 0, exp_timeout: 1, exp_end: 0};
        vecs[4] = '{lim: 2,   stop_at: 1,  exp_elapsed: 0,   exp_done: 1, exp_timeout: 0, exp_end: 1};
        vecs[5] = '{lim: 1,   stop_at: 0,  exp_elapsed: 1,   exp_done: 0, exp_timeout: 1, exp_end: 4};
        vecs[6] = '{lim: 7,   stop_at: 4,  exp_elapsed: 0,   exp_done: 1, exp_timeout: 0, exp_end: 4};
        vecs[7] = '{lim: 255, stop_at: 0,  exp_elapsed: 255, exp_done: 0, exp_timeout: 1, exp_end: 1020};

        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        limit   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 0);
        check("reset.done", 32'(done), 0);
        check("reset.timeout", 32'(timeout), 0);
        check("reset.elapsed", 32'(elapsed), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            pulse_at = -1;
            pulse_elapsed = -1;
            got_done = 0;
            got_timeout = 0;
            apply_stimulus(1, 0, vecs[i].lim, $sformatf("vec%0d.start", i));
            if (done || timeout) begin
                pulse_at = 0; pulse_elapsed = int'(elapsed);
                got_done = done; got_timeout = timeout;
            end
            for (int off = 1; off <= 2000 && pulse_at < 0; off++) begin
                apply_stimulus(0, vecs[i].stop_at == off, 0, $sformatf("vec%0d.run", i));
                if (done || timeout) begin
                    pulse_at = off; pulse_elapsed = int'(elapsed);
                    got_done = done; got_timeout = timeout;
                end
            end
            check($sformatf("vec%0d.end_cycle", i), 32'(pulse_at), vecs[i].exp_end);
            check($sformatf("vec%0d.final_elapsed", i), 32'(pulse_elapsed), vecs[i].exp_elapsed);
            check($sformatf("vec%0d.got_done", i), 32'(got_done), int'(vecs[i].exp_done));
            check($sformatf("vec%0d.got_timeout", i), 32'(got_timeout), int'(vecs[i].exp_timeout));
            apply_stimulus(0, 0, 0, $sformatf("vec%0d.after", i));
            apply_stimulus(0, 1, 0, $sformatf("vec%0d.stop_in_hold", i));
            check($sformatf("vec%0d.hold_done", i), 32'(done), 0);
            check($sformatf("vec%0d.hold_elapsed", i), 32'(elapsed), vecs[i].exp_elapsed);
        end

        // Restart mid-run with simultaneous start and stop.
        apply_stimulus(1, 0, 9, "restart.start");
        for (int c = 1; c <= 5; c++) apply_stimulus(0, 0, 0, "restart.run");
        check("restart.elapsed_before", 32'(elapsed), 1);
        apply_stimulus(1, 1, 2, "restart.again");
        check("restart.busy", 32'(busy), 1);
        check("restart.elapsed0", 32'(elapsed), 0);
        check("restart.no_done", 32'(done), 0);
        for (int c = 1; c <= 7; c++) begin
            apply_stimulus(0, 0, 0, "restart.wait");
            check("restart.early_timeout", 32'(timeout), 0);
        end
        apply_stimulus(0, 0, 0, "restart.limit");
        check("restart.timeout", 32'(timeout), 1);
        check("restart.final_elapsed", 32'(elapsed), 2);

        // Asynchronous reset between clock edges while measuring.
        apply_stimulus(1, 0, 20, "areset.start");
        for (int c = 1; c <= 16; c++) apply_stimulus(0, 0, 0, "areset.run");
        check("areset.elapsed4", 32'(elapsed), 4);
        #1;
        reset_n = 1'b0;
        #1;
        check("areset.busy", 32'(busy), 0);
        check("areset.elapsed", 32'(elapsed), 0);
        check("areset.done", 32'(done), 0);
        check("areset.timeout", 32'(timeout), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(0, 1, 0, "areset.stop_ignored");
        check("areset.stop_no_done", 32'(done), 0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            apply_stimulus((c == 0) || ($urandom_range(0, 19) == 0),
                           $urandom_range(0, 5) == 0,
                           int'($urandom_range(0, 12)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
